// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer; OVS-times oversampled, 8 data bits LSB-first, 1 stop bit.
// Latency: rx_valid rises 1 clk after the stop-bit sample tick; start sync adds 2 clk ahead of that.
// Backpressure: none on the line; a byte finishing while rx_valid is unacked is dropped and sets oerr.
//
// Optional parity: define UART_RX_PARITY_EN to add a PAR state and the parity_odd input.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   en              receiver enable (0 aborts any frame in progress)
//   abaud_busy      auto-baud owns the line; aborts/holds the receiver in IDLE
//   brg             divisor, one oversample tick every brg+1 clk (latched at start detect)
//   parity_odd      (UART_RX_PARITY_EN only) 1 = odd parity expected, 0 = even
//   rx              asynchronous serial input, idle high
//   rx_ack          consumer has taken rx_data
//   oerr_clr        clears the sticky overrun flag
//   rx_data         last received byte
//   rx_valid        rx_data holds an unread byte
//   rxif            one-cycle pulse when a byte is loaded
//   ferr, perr      framing / parity error of the byte in rx_data
//   oerr            sticky overrun flag
//   rx_busy         frame reception in progress
module uart_rx_ctrl #(
  parameter int BRG_W = 16,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             abaud_busy,
  input  logic [BRG_W-1:0] brg,
`ifdef UART_RX_PARITY_EN
  input  logic             parity_odd,
`endif
  input  logic             rx,
  input  logic             rx_ack,
  input  logic             oerr_clr,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rxif,
  output logic             ferr,
  output logic             perr,
  output logic             oerr,
  output logic             rx_busy
);

  localparam int OS_W = $clog2(OVS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_n;

  // Synchronizer plus one extra stage for falling-edge detection.
  logic rx_m, rx_s, rx_d;

  logic [BRG_W-1:0] div_cnt;
  logic [BRG_W-1:0] brg_q;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             perr_calc;

  logic tick, os_half, os_last, start_det, abort;
  logic os_clr, sample_data, frame_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // The divisor only runs inside a frame; it is restarted by start detection
  // so the half-bit sample point is measured from the synchronized edge.
  assign tick      = (state != IDLE) && (div_cnt == brg_q);
  assign os_half   = tick && (os_cnt == OS_W'(OVS/2 - 1));
  assign os_last   = tick && (os_cnt == OS_W'(OVS - 1));
  assign start_det = (state == IDLE) && en && !abaud_busy && rx_d && !rx_s;
  assign abort     = (state != IDLE) && (!en || abaud_busy);
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    os_clr      = 1'b0;
    sample_data = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_det) begin
          state_n = START;
        end
      end
      START: begin
        if (abort) begin
          state_n = IDLE;
        end else if (os_half) begin
          // Line back high at mid start bit: treat as a glitch.
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            os_clr  = 1'b1;
          end
        end
      end
      DATA: begin
        if (abort) begin
          state_n = IDLE;
        end else if (os_last) begin
          sample_data = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PAR;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (abort) begin
          state_n = IDLE;
        end else if (os_last) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (os_last) begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Bit timing and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      brg_q   <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (start_det) begin
        div_cnt <= '0;
        brg_q   <= brg;
        os_cnt  <= '0;
      end else if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + BRG_W'(1);
        // OVS is a power of two, so os_cnt wraps to 0 on every bit boundary.
        if (os_clr) begin
          os_cnt <= '0;
        end else if (tick) begin
          os_cnt <= os_cnt + OS_W'(1);
        end
      end
      if (os_clr) begin
        bit_cnt <= '0;
      end else if (sample_data) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (sample_data) begin
        shift[bit_cnt] <= rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parbit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parbit <= 1'b0;
    end else if (state == PAR && os_last && !abort) begin
      parbit <= rx_s;
    end
  end

  assign perr_calc = (((^shift) ^ parbit) != parity_odd);
`else
  assign perr_calc = 1'b0;
`endif

  // Output holding register and handshake. A load in the same cycle as an
  // ack takes priority, so the new byte is never lost to the old byte's ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rxif     <= 1'b0;
      ferr     <= 1'b0;
      perr     <= 1'b0;
      oerr     <= 1'b0;
    end else begin
      rxif <= 1'b0;
      if (frame_done && (!rx_valid || rx_ack)) begin
        rx_data  <= shift;
        ferr     <= ~rx_s;
        perr     <= perr_calc;
        rx_valid <= 1'b1;
        rxif     <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
      // Set beats clear when both occur together.
      if (frame_done && rx_valid && !rx_ack) begin
        oerr <= 1'b1;
      end else if (oerr_clr) begin
        oerr <= 1'b0;
      end
    end
  end

endmodule
